chrono_counter: RTL and testbench

CHRONO_COUNTER -- requirements
Module: chrono_counter

---
 rtl/chrono_pkg.sv | 16 +
 rtl/tick_gen.sv | 29 ++
 rtl/chrono_counter.sv | 129 ++++++++++++
 tb/tb_chrono_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/chrono_pkg.sv
// Shared types and default constants for the stopwatch core and its prescaler.
package chrono_pkg;

    localparam int unsigned DEFAULT_CLK_HZ    = 50_000_000;
    localparam int unsigned DEFAULT_TICK_HZ   = 100;
    localparam int unsigned DEFAULT_MAX_COUNT = 59_999;
    localparam int unsigned COUNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAP,
        PAUSE
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and pulses tick on the wrap cycle.
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned W = $clog2(DIV);

    logic [W-1:0] cnt_q;
    logic         at_top;

    assign at_top = (cnt_q == W'(DIV - 1));
    // A clear or reset on the same edge wins, so no count step leaks through.
    assign tick   = en & at_top & ~sync_clr & ~rst;

    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_top ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/chrono_counter.sv
// Stopwatch core: button press detection, run/lap/pause FSM, counter with wrap flag and lap hold.
module chrono_counter
    import chrono_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int unsigned TICK_HZ   = DEFAULT_TICK_HZ,
    parameter int unsigned MAX_COUNT = DEFAULT_MAX_COUNT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_stop,
    input  logic               lap,
    input  logic               clear,
    output logic [COUNT_W-1:0] value,
    output logic               running,
    output logic               lap_active,
    output logic               ovf,
    output logic               tick
);

    localparam int unsigned        DIV     = CLK_HZ / TICK_HZ;
    localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

    state_e             state_q, state_d;
    logic               ss_q, lap_btn_q, clr_q;
    logic               ss_press, lap_press, clr_press;
    logic [COUNT_W-1:0] count_q, lap_q;
    logic               ovf_q;
    logic               run_en;

    assign ss_press  = start_stop & ~ss_q;
    assign lap_press = lap & ~lap_btn_q;
    assign clr_press = clear & ~clr_q;
    assign run_en    = (state_q == RUN) || (state_q == LAP);

    // Preset to 1 so a button held through reset does not count as a press on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q      <= 1'b1;
            lap_btn_q <= 1'b1;
            clr_q     <= 1'b1;
        end else begin
            ss_q      <= start_stop;
            lap_btn_q <= lap;
            clr_q     <= clear;
        end
    end

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (run_en),
        .sync_clr (clr_press),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            state_d = IDLE;
        end else if (ss_press) begin
            unique case (state_q)
                IDLE:  state_d = RUN;
                RUN:   state_d = PAUSE;
                LAP:   state_d = PAUSE;
                PAUSE: state_d = RUN;
            endcase
        end else if (lap_press) begin
            case (state_q)
                RUN:     state_d = LAP;
                LAP:     state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        running    = 1'b0;
        lap_active = 1'b0;
        value      = count_q;
        if (rst) begin
            value = '0;
        end else begin
            case (state_q)
                RUN: running = 1'b1;
                LAP: begin
                    running    = 1'b1;
                    lap_active = 1'b1;
                    value      = lap_q;
                end
                default: running = 1'b0;
            endcase
        end
    end

    assign ovf = ovf_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst || clr_press) begin
            count_q <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (tick) begin
                if (count_q == MAX_VAL) begin
                    count_q <= '0;
                    ovf_q   <= 1'b1;
                end else begin
                    count_q <= count_q + COUNT_W'(1);
                end
            end
            // Latch the pre-increment count on lap entry, even if a tick coincides.
            if (state_q == RUN && state_d == LAP) begin
                lap_q <= count_q;
            end
        end
    end

endmodule

// File: tb/tb_chrono_counter.sv
// Scoreboard bench for chrono_counter with DIV=10, MAX_COUNT=15.
module tb_chrono_counter;

    typedef struct {
        int cyc;
        int val;
        int ovf;
    } tick_t;

    typedef struct {
        int val;
        int run;
        int lapa;
        int ovf;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b1;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] value;
    logic        running, lap_active, ovf, tick;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    tick_t exp_q[$];
    st_t   st_q[$];
    string st_name_q[$];
    tick_t tk_e;
    st_t   st_e;
    string st_n;

    chrono_counter #(
        .CLK_HZ    (10),
        .TICK_HZ   (1),
        .MAX_COUNT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .value      (value),
        .running    (running),
        .lap_active (lap_active),
        .ovf        (ovf),
        .tick       (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e - 1) step(1);
    endtask

    // mask: bit0 start_stop, bit1 lap, bit2 clear; returns the index of the press edge.
    task automatic press(input int mask, output int edge_idx);
        start_stop = mask[0];
        lap        = mask[1];
        clear      = mask[2];
        step(1);
        edge_idx   = cyc;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic push_tick(input int c, input int v, input int o);
        tick_t t;
        t.cyc = c;
        t.val = v;
        t.ovf = o;
        exp_q.push_back(t);
    endtask

    task automatic push_st(input string nm, input int v, input int r, input int la, input int o);
        st_t s;
        s.val  = v;
        s.run  = r;
        s.lapa = la;
        s.ovf  = o;
        st_q.push_back(s);
        st_name_q.push_back(nm);
    endtask

    // Tick monitor: each tick pulse pops one expected tick (edge index, shown value, ovf after it).
    initial begin
        forever begin
            @(negedge clk);
            if (tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("tick_expected", exp_q.size(), 1);
                    @(negedge clk);
                end else begin
                    tk_e = exp_q.pop_front();
                    chk("tick_edge", cyc + 1, tk_e.cyc);
                    @(negedge clk);
                    chk("tick_value", int'(value), tk_e.val);
                    chk("tick_ovf", int'(ovf), tk_e.ovf);
                end
            end
        end
    end

    // Status monitor: compares every queued status expectation at the next falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (st_q.size() > 0) begin
                st_e = st_q.pop_front();
                st_n = st_name_q.pop_front();
                chk({st_n, ".value"}, int'(value), st_e.val);
                chk({st_n, ".running"}, int'(running), st_e.run);
                chk({st_n, ".lap_active"}, int'(lap_active), st_e.lapa);
                chk({st_n, ".ovf"}, int'(ovf), st_e.ovf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c, r, q, s, s2, e;
        step(2);
        push_st("reset", 0, 0, 0, 0);
        step(1);
        rst = 1'b0;
        step(3);
        push_st("held_button", 0, 0, 0, 0);
        start_stop = 1'b0;
        step(1);

        press(1, c);
        push_st("start", 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) push_tick(c + 10 * i, i, 0);

        // Pause three cycles after the value-5 tick; prescaler is left at 3.
        goto_edge(c + 53);
        press(1, e);
        push_st("pause", 5, 0, 0, 0);
        step(50);
        push_st("pause_hold", 5, 0, 0, 0);

        press(1, r);
        push_st("resume", 5, 1, 0, 0);
        push_tick(r + 7, 6, 0);

        goto_edge(r + 10);
        press(2, e);
        push_st("lap_enter", 6, 1, 1, 0);
        push_tick(r + 17, 6, 0);
        push_tick(r + 27, 6, 0);
        push_tick(r + 37, 6, 0);
        goto_edge(r + 40);
        press(2, e);
        push_st("lap_exit", 9, 1, 0, 0);
        push_tick(r + 47, 10, 0);
        push_tick(r + 57, 10, 0);

        // Lap entry on a tick edge holds the pre-increment count.
        goto_edge(r + 57);
        press(2, e);
        push_st("lap_on_tick", 10, 1, 1, 0);
        goto_edge(r + 60);
        press(1, e);
        push_st("lap_to_pause_live", 11, 0, 0, 0);
        step(5);

        press(1, q);
        push_st("resume2", 11, 1, 0, 0);
        for (int i = 0; i < 4; i++) push_tick(q + 7 + 10 * i, 12 + i, 0);
        push_tick(q + 47, 0, 1);
        push_tick(q + 57, 1, 1);
        goto_edge(q + 60);
        press(3, e);
        push_st("ss_lap_same_edge", 1, 0, 0, 1);
        step(3);
        press(4, e);
        push_st("clear", 0, 0, 0, 0);

        step(3);
        press(1, s);
        push_st("start3", 0, 1, 0, 0);
        goto_edge(s + 5);
        press(5, e);
        push_st("clear_beats_ss", 0, 0, 0, 0);
        step(20);

        press(1, s2);
        push_tick(s2 + 10, 1, 0);
        goto_edge(s2 + 20);
        rst = 1'b1;
        step(1);
        push_st("rst_mid_run", 0, 0, 0, 0);
        step(1);
        rst = 1'b0;
        step(15);
        push_st("after_rst", 0, 0, 0, 0);
        step(3);
        chk("tick_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
